// File: rtl/mem_access_unit.sv
// Load/store sequencer between the MEM stage and a 64-bit-word data memory.
// Partial stores use read-modify-write; loads are lane-extracted and sign/zero-extended.
module mem_access_unit #(
    parameter int unsigned DATA_BITS = 64,
    parameter int unsigned ADDR_BITS = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_wr,
    input  logic [1:0]           req_size,
    input  logic                 req_signed,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [DATA_BITS-1:0] req_wdata,
    output logic                 resp_valid,
    output logic [DATA_BITS-1:0] resp_rdata,
    output logic                 resp_misaligned,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [DATA_BITS-1:0] mem_d_in,
    input  logic [DATA_BITS-1:0] mem_d_out,
    output logic                 mem_en,
    output logic                 mem_wr
);

    typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

    state_t               state, state_n;
    logic                 wr_q, sgn_q;
    logic [1:0]           size_q;
    logic [2:0]           lane_q;
    logic [DATA_BITS-1:0] wdata_q;

    logic                 resp_valid_q, resp_valid_n;
    logic [DATA_BITS-1:0] resp_rdata_q, resp_rdata_n;
    logic                 resp_mis_q, resp_mis_n;
    logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_n;
    logic [DATA_BITS-1:0] mem_d_in_q, mem_d_in_n;
    logic                 mem_en_q, mem_en_n;
    logic                 mem_wr_q, mem_wr_n;

    logic                 req_mis;
    logic [5:0]           shamt;
    logic [DATA_BITS-1:0] lane_mask, shifted, load_ext, merged;
    logic                 sign_bit;

    function automatic logic [DATA_BITS-1:0] size_mask(input logic [1:0] s);
        case (s)
            2'b00:   return DATA_BITS'(64'h0000_0000_0000_00FF);
            2'b01:   return DATA_BITS'(64'h0000_0000_0000_FFFF);
            2'b10:   return DATA_BITS'(64'h0000_0000_FFFF_FFFF);
            default: return '1;
        endcase
    endfunction

    assign req_ready       = (state == IDLE) && !rst;
    assign resp_valid      = resp_valid_q;
    assign resp_rdata      = resp_rdata_q;
    assign resp_misaligned = resp_mis_q;
    assign mem_addr        = mem_addr_q;
    assign mem_d_in        = mem_d_in_q;
    // Reset blocks the memory strobe in the same cycle so an in-flight WR never lands
    assign mem_en          = mem_en_q && !rst;
    assign mem_wr          = mem_wr_q && !rst;

    assign req_mis = ((req_size == 2'b01) && req_addr[0]) ||
                     ((req_size == 2'b10) && (req_addr[1:0] != 2'b00)) ||
                     ((req_size == 2'b11) && (req_addr[2:0] != 3'b000));

    // Lane extraction/extension for loads and lane merge for partial stores
    always_comb begin
        shamt     = {lane_q, 3'b000};
        lane_mask = size_mask(size_q) << shamt;
        shifted   = mem_d_out >> shamt;
        case (size_q)
            2'b00:   sign_bit = shifted[7];
            2'b01:   sign_bit = shifted[15];
            2'b10:   sign_bit = shifted[31];
            default: sign_bit = 1'b0;
        endcase
        load_ext = shifted & size_mask(size_q);
        if (sgn_q && sign_bit)
            load_ext = load_ext | ~size_mask(size_q);
        merged = (mem_d_out & ~lane_mask) | ((wdata_q << shamt) & lane_mask);
    end

    always_comb begin
        state_n      = state;
        resp_valid_n = 1'b0;
        resp_rdata_n = '0;
        resp_mis_n   = 1'b0;
        mem_en_n     = 1'b0;
        mem_wr_n     = 1'b0;
        mem_addr_n   = mem_addr_q;
        mem_d_in_n   = mem_d_in_q;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    mem_addr_n = {3'b000, req_addr[ADDR_BITS-1:3]};
                    if (req_mis) begin
                        state_n      = RESP;
                        resp_valid_n = 1'b1;
                        resp_mis_n   = 1'b1;
                    end else if (req_wr && (req_size == 2'b11)) begin
                        state_n    = WR;
                        mem_en_n   = 1'b1;
                        mem_wr_n   = 1'b1;
                        mem_d_in_n = req_wdata;
                    end else begin
                        state_n  = RD;
                        mem_en_n = 1'b1;
                    end
                end
            end
            RD: state_n = CAP;
            CAP: begin
                if (wr_q) begin
                    state_n    = WR;
                    mem_en_n   = 1'b1;
                    mem_wr_n   = 1'b1;
                    mem_d_in_n = merged;
                end else begin
                    state_n      = RESP;
                    resp_valid_n = 1'b1;
                    resp_rdata_n = load_ext;
                end
            end
            WR: begin
                state_n      = RESP;
                resp_valid_n = 1'b1;
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_mis_q   <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_d_in_q   <= '0;
            wr_q         <= 1'b0;
            sgn_q        <= 1'b0;
            size_q       <= 2'b00;
            lane_q       <= 3'b000;
            wdata_q      <= '0;
        end else begin
            state        <= state_n;
            resp_valid_q <= resp_valid_n;
            resp_rdata_q <= resp_rdata_n;
            resp_mis_q   <= resp_mis_n;
            mem_en_q     <= mem_en_n;
            mem_wr_q     <= mem_wr_n;
            mem_addr_q   <= mem_addr_n;
            mem_d_in_q   <= mem_d_in_n;
            if ((state == IDLE) && req_valid) begin
                wr_q    <= req_wr;
                sgn_q   <= req_signed;
                size_q  <= req_size;
                lane_q  <= req_addr[2:0];
                wdata_q <= req_wdata;
            end
        end
    end

endmodule
